// File: rtl/hazard3_apb_pkg.sv
// Shared constants for the hazard3 APB initiator.
// State encoding and APB data width.
package hazard3_apb_pkg;

  localparam int W_DATA = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/hazard3_apb_watchdog.sv
// Wait-state watchdog for the APB initiator.
// Ports: clk, rst, clr_i (restart), en_i (count), expire_o.
module hazard3_apb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_wd;
    assign unused_wd = &{1'b0, clk, rst, clr_i, en_i};
    assign expire_o  = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counts unanswered ACCESS cycles and saturates at
    // LIMIT, so the next ACCESS cycle is the last one.
    always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
        cnt_d = '0;
      end else if (en_i && (cnt_q != LIMIT)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign expire_o = (cnt_q == LIMIT);
  end

endmodule

// File: rtl/hazard3_apb_initiator.sv
// Single-outstanding APB3 requester with a watchdog.
// Ports: req_* in, rsp_* out, APB p* bus; clk, rst (sync, high).
module hazard3_apb_initiator
  import hazard3_apb_pkg::*;
#(
  parameter int W_PADDR = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [W_PADDR-1:0] req_addr,
  input  logic [W_DATA-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W_DATA-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic               rsp_timeout,
  output logic [W_PADDR-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [W_DATA-1:0]  pwdata,
  input  logic [W_DATA-1:0]  prdata,
  input  logic               pready,
  input  logic               pslverr
);

  logic [1:0]         state_q, state_d;
  logic [W_PADDR-1:0] paddr_q, paddr_d;
  logic               pwrite_q, pwrite_d;
  logic [W_DATA-1:0]  pwdata_q, pwdata_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [W_DATA-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               rsp_to_q, rsp_to_d;
  logic               wd_expire;

  hazard3_apb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_SETUP),
    .en_i     ((state_q == ST_ACCESS) && !pready),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          psel_d   = 1'b1;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready takes priority over a same-cycle expiry.
        if (pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          rsp_to_d    = 1'b0;
          state_d     = ST_RESP;
        end else if (wd_expire) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign paddr       = paddr_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

endmodule

// File: tb/tb_hazard3_apb_initiator.sv
// Testbench for hazard3_apb_initiator (TIMEOUT=4).
// Directed table, random transfers, backpressure and reset cases.
module tb_hazard3_apb_initiator;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  always #5 clk = ~clk;

  hazard3_apb_initiator #(
    .W_PADDR (16),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .paddr       (paddr),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  typedef struct {
    bit          write;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prd;
    bit          slverr;
    int          hold;
    bit          hold_valid;
    logic [31:0] e_rdata;
    bit          e_err;
    bit          e_to;
    int          e_lat;
  } txn_t;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: a transfer lasts up to TO+1 ACCESS cycles;
  // pready on cycle k <= TO+1 completes it normally.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    if (t.waits <= TO) begin
      r.e_lat   = 3 + t.waits;
      r.e_rdata = t.write ? 32'h0 : t.prd;
      r.e_err   = t.slverr;
      r.e_to    = 1'b0;
    end else begin
      r.e_lat   = 3 + TO;
      r.e_rdata = 32'h0;
      r.e_err   = 1'b1;
      r.e_to    = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle, just after an edge.
  task automatic run_txn(input txn_t t, input string tag);
    int cyc;
    int acc;
    bit bad;
    logic [31:0] r0;
    logic        e0, t0;
    chk({tag, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1;
    req_write = t.write;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    pready    = 1'b0;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    chk({tag, ".setup"}, {30'h0, psel, penable}, 32'h2);
    cyc = 1;
    acc = 0;
    bad = 1'b0;
    while (!rsp_valid && cyc < 40) begin
      if (psel && penable) begin
        acc++;
        if (paddr !== t.addr || pwrite !== t.write ||
            pwdata !== t.wdata) bad = 1'b1;
        if (acc == t.waits + 1) begin
          pready  = 1'b1;
          prdata  = t.prd;
          pslverr = t.slverr;
        end else begin
          pready  = 1'b0;
          prdata  = $urandom;
          pslverr = 1'($urandom);
        end
      end else begin
        if (!psel) bad = 1'b1;
        pready  = 1'($urandom);
        prdata  = $urandom;
        pslverr = 1'($urandom);
      end
      tick();
      cyc++;
    end
    pready = 1'b0;
    chk({tag, ".bus_stable"}, {31'h0, bad}, 32'h0);
    chk({tag, ".latency"}, cyc, t.e_lat);
    chk({tag, ".rdata"}, rsp_rdata, t.e_rdata);
    chk({tag, ".err_to"}, {30'h0, rsp_err, rsp_timeout},
        {30'h0, t.e_err, t.e_to});
    chk({tag, ".released"}, {29'h0, psel, penable, req_ready}, 32'h0);
    r0  = rsp_rdata;
    e0  = rsp_err;
    t0  = rsp_timeout;
    bad = 1'b0;
    for (int i = 0; i < t.hold; i++) begin
      if (t.hold_valid) begin
        req_valid = 1'b1;
        req_addr  = 16'($urandom);
      end
      pready = 1'($urandom);
      tick();
      if (!rsp_valid || rsp_rdata !== r0 || rsp_err !== e0 ||
          rsp_timeout !== t0 || req_ready || psel) bad = 1'b1;
    end
    if (t.hold > 0) chk({tag, ".hold"}, {31'h0, bad}, 32'h0);
    pready    = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk({tag, ".done"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  txn_t tab[7];
  txn_t t;

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    tab[0] = '{1, 16'h0010, 32'hFFFFFF00, 0, 32'h0, 0, 0, 0,
               32'h0, 0, 0, 3};
    tab[1] = '{0, 16'h0008, 32'h0, 3, 32'h12345678, 0, 0, 0,
               32'h12345678, 0, 0, 6};
    tab[2] = '{0, 16'h0020, 32'h0, 0, 32'hDEADBEEF, 1, 0, 0,
               32'hDEADBEEF, 1, 0, 3};
    tab[3] = '{0, 16'h0030, 32'h0, 100, 32'h55AA55AA, 0, 0, 0,
               32'h0, 1, 1, 7};
    tab[4] = '{0, 16'h0034, 32'h0, 4, 32'hA5A5A5A5, 0, 0, 0,
               32'hA5A5A5A5, 0, 0, 7};
    tab[5] = '{1, 16'hFFFC, 32'h01234567, 2, 32'h77, 1, 0, 0,
               32'h0, 1, 0, 5};
    tab[6] = '{1, 16'h0044, 32'hCAFEF00D, 1, 32'h0, 0, 10, 1,
               32'h0, 0, 0, 4};

    tick();
    tick();
    chk("reset.ctrl",
        {25'h0, psel, penable, pwrite, rsp_valid, rsp_err,
         rsp_timeout, req_ready}, 32'h1);
    chk("reset.paddr", {16'h0, paddr}, 32'h0);
    chk("reset.pwdata", pwdata, 32'h0);
    chk("reset.rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    tick();

    foreach (tab[i]) run_txn(tab[i], $sformatf("dir%0d", i));

    // Reset while a read sits in wait states.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 16'h0050;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rst.in_access", {30'h0, psel, penable}, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.dropped",
        {28'h0, psel, penable, rsp_valid, req_ready}, 32'h1);
    pready  = 1'b1;
    prdata  = 32'h1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (rsp_valid || psel) seen = 1'b1;
      end
      chk("rst.no_rsp", {31'h0, seen}, 32'h0);
    end
    pready = 1'b0;

    for (int i = 0; i < 40; i++) begin
      t.write      = 1'($urandom);
      t.addr       = 16'($urandom);
      t.wdata      = $urandom;
      t.waits      = $urandom_range(0, TO + 3);
      t.prd        = $urandom;
      t.slverr     = ($urandom_range(0, 3) == 0);
      t.hold       = $urandom_range(0, 3);
      t.hold_valid = 1'($urandom);
      run_txn(model(t), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1);
  end

endmodule
